// File: rtl/mnist_pkg.sv
// mnist_pkg: shared frame geometry and state encodings for the MNIST frame-buffer controller
package mnist_pkg;
  localparam int IMG_W  = 28;
  localparam int NPIX   = IMG_W * IMG_W;
  localparam int ADDR_W = 10;
  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_BUSY} bank_st_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_RUN} rd_st_t;
endpackage

// File: rtl/mnist_fb_bank_tracker.sv
// mnist_fb_bank_tracker: per-bank FREE/FILLING/FULL/BUSY state and lowest-FULL-bank select
module mnist_fb_bank_tracker (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_acc,
  input  logic       i_last,
  input  logic       i_wbank,
  input  logic       i_start,
  input  logic       i_sbank,
  input  logic       i_done,
  input  logic       i_dbank,
  output logic [1:0] o_st0,
  output logic [1:0] o_st1,
  output logic       o_full,
  output logic       o_sel
);
  import mnist_pkg::*;
  bank_st_t r_st [2];
  always_ff @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (rst) r_st[k] <= B_FREE;
      else if (i_acc && i_wbank == 1'(k)) r_st[k] <= i_last ? B_FULL : B_FILLING;
      else if (i_start && i_sbank == 1'(k)) r_st[k] <= B_BUSY;
      else if (i_done && i_dbank == 1'(k)) r_st[k] <= B_FREE;
  assign o_st0  = r_st[0];
  assign o_st1  = r_st[1];
  assign o_full = r_st[0] == B_FULL || r_st[1] == B_FULL;
  assign o_sel  = r_st[0] != B_FULL;
endmodule

// File: rtl/mnist_fb_ctrl.sv
// mnist_fb_ctrl: ping-pong MNIST frame-buffer writer with start/done handoff to inference
module mnist_fb_ctrl #(
  parameter int NPIX   = mnist_pkg::NPIX,
  parameter int ADDR_W = mnist_pkg::ADDR_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_pixel,
  input  logic            in_sof,
  output logic            fb_wr_en,
  output logic [ADDR_W:0] fb_wr_addr,
  output logic            fb_wr_data,
  output logic            inf_start,
  output logic            inf_bank,
  input  logic            inf_done,
  output logic [7:0]      resync_cnt,
  output logic [15:0]     frame_cnt
);
  import mnist_pkg::*;
  logic              r_en, r_wbank, r_wr_en, r_wr_data, r_start, r_bank;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W:0]   r_wr_addr;
  logic [7:0]        r_resync;
  logic [15:0]       r_frames;
  rd_st_t            r_rd;
  logic [1:0]        w_st0, w_st1, w_wst;
  logic              w_acc, w_last, w_resync, w_full, w_sel, w_go, w_rel;
  logic [ADDR_W-1:0] w_pidx;
  assign w_wst      = r_wbank ? w_st1 : w_st0;
  assign in_ready   = r_en && (w_wst == B_FREE || w_wst == B_FILLING);
  assign w_acc      = in_valid && in_ready;
  assign w_resync   = in_sof && r_idx != '0;
  assign w_pidx     = in_sof ? '0 : r_idx;
  assign w_last     = w_pidx == ADDR_W'(NPIX - 1);
  assign w_go       = r_rd == R_IDLE && w_full;
  assign w_rel      = r_rd == R_RUN && inf_done;
  assign fb_wr_en   = r_wr_en;
  assign fb_wr_addr = r_wr_addr;
  assign fb_wr_data = r_wr_data;
  assign inf_start  = r_start;
  assign inf_bank   = r_bank;
  assign resync_cnt = r_resync;
  assign frame_cnt  = r_frames;
  mnist_fb_bank_tracker u_banks (
    .clk     (clk),
    .rst     (rst),
    .i_acc   (w_acc),
    .i_last  (w_last),
    .i_wbank (r_wbank),
    .i_start (w_go),
    .i_sbank (w_sel),
    .i_done  (w_rel),
    .i_dbank (r_bank),
    .o_st0   (w_st0),
    .o_st1   (w_st1),
    .o_full  (w_full),
    .o_sel   (w_sel)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_en      <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 1'b0;
      r_idx     <= '0;
      r_wbank   <= 1'b0;
      r_resync  <= '0;
    end else begin
      r_en    <= 1'b1;
      r_wr_en <= w_acc;
      if (w_acc) begin
        r_wr_addr <= {r_wbank, w_pidx};
        r_wr_data <= in_pixel;
        r_idx     <= w_last ? '0 : w_pidx + ADDR_W'(1);
        r_wbank   <= r_wbank ^ w_last;
        if (w_resync && r_resync != 8'hff) r_resync <= r_resync + 8'd1;
      end
    end
  always_ff @(posedge clk)
    if (rst) begin
      r_rd     <= R_IDLE;
      r_start  <= 1'b0;
      r_bank   <= 1'b0;
      r_frames <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_rd)
        R_IDLE: if (w_full) begin
          r_rd     <= R_START;
          r_start  <= 1'b1;
          r_bank   <= w_sel;
          r_frames <= r_frames + 16'd1;
        end
        R_START: r_rd <= R_RUN;
        R_RUN:   if (inf_done) r_rd <= R_IDLE;
        default: r_rd <= R_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mnist_fb_ctrl.sv
// tb_mnist_fb_ctrl: scoreboard bench for the ping-pong MNIST frame-buffer controller
module tb_mnist_fb_ctrl;
  typedef struct { logic [10:0] addr; logic d; int cyc; } wr_t;
  typedef struct { logic b; logic [783:0] pix; } fr_t;
  logic clk = 0, rst = 1, in_valid = 0, in_pixel = 0, in_sof = 0, inf_done = 0;
  logic in_ready, fb_wr_en, fb_wr_data, inf_start, inf_bank;
  logic [10:0] fb_wr_addr;
  logic [7:0] resync_cnt;
  logic [15:0] frame_cnt;
  int n_cmp = 0, n_err = 0, cyc = 0, n_starts = 0, m_resync = 0;
  int last_wr [2] = '{0, 0};
  logic auto_eng = 0, m_wb = 0;
  logic [9:0] m_idx = '0;
  logic [783:0] cur = '0;
  logic [783:0] shadow [2];
  wr_t exp_wr [$];
  fr_t exp_fr [$];
  mnist_fb_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .in_sof     (in_sof),
    .fb_wr_en   (fb_wr_en),
    .fb_wr_addr (fb_wr_addr),
    .fb_wr_data (fb_wr_data),
    .inf_start  (inf_start),
    .inf_bank   (inf_bank),
    .inf_done   (inf_done),
    .resync_cnt (resync_cnt),
    .frame_cnt  (frame_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] ex);
    n_cmp++;
    assert (obs === ex) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, ex);
    end
  endtask
  always @(negedge clk) begin
    wr_t w;
    fr_t f;
    if (fb_wr_en) begin
      if (exp_wr.size() == 0) chk("wr_unexpected", 32'(fb_wr_en), 0);
      else begin
        w = exp_wr.pop_front();
        chk("wr_addr", 32'(fb_wr_addr), 32'(w.addr));
        chk("wr_data", 32'(fb_wr_data), 32'(w.d));
        chk("wr_lag", cyc, w.cyc);
      end
      shadow[fb_wr_addr[10]][fb_wr_addr[9:0]] = fb_wr_data;
      last_wr[fb_wr_addr[10]] = cyc;
    end
    if (inf_start) begin
      n_starts++;
      chk("start_after_write", 32'(cyc > last_wr[inf_bank]), 1);
      if (exp_fr.size() == 0) chk("start_unexpected", 32'(inf_start), 0);
      else begin
        f = exp_fr.pop_front();
        chk("start_bank", 32'(inf_bank), 32'(f.b));
        chk("frame_contents", 32'(shadow[inf_bank] === f.pix), 1);
      end
      shadow[inf_bank] = 'x;
    end
  end
  initial forever begin
    @(negedge clk);
    if (auto_eng && inf_start) begin
      repeat ($urandom_range(2000, 5)) @(negedge clk);
      inf_done = 1;
      @(negedge clk);
      inf_done = 0;
    end
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_done();
    inf_done = 1;
    @(negedge clk);
    inf_done = 0;
  endtask
  task automatic send(input logic p, input logic s, input logic d);
    int n = 0;
    logic [9:0] pi;
    in_valid = 1;
    in_pixel = p;
    in_sof = s;
    while (!in_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 32'(in_ready), 1);
      $fatal(1, "in_ready never rose");
    end
    if (d) inf_done = 1;
    pi = s ? 10'd0 : m_idx;
    if (s && m_idx != 0) m_resync++;
    exp_wr.push_back('{addr: {m_wb, pi}, d: p, cyc: cyc + 1});
    cur[pi] = p;
    if (pi == 10'd783) begin
      exp_fr.push_back('{b: m_wb, pix: cur});
      m_idx = '0;
      m_wb = ~m_wb;
    end else m_idx = pi + 10'd1;
    @(negedge clk);
    if (d) inf_done = 0;
    in_valid = 0;
  endtask
  task automatic wait_starts(input int k);
    int n = 0;
    while (n_starts < k && n < 6000) begin
      @(negedge clk);
      n++;
    end
    chk("start_count", n_starts, k);
  endtask
  task automatic do_reset();
    rst = 1;
    in_valid = 0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_wr_en", 32'(fb_wr_en), 0);
    chk("rst_wr_addr", 32'(fb_wr_addr), 0);
    chk("rst_wr_data", 32'(fb_wr_data), 0);
    chk("rst_inf_start", 32'(inf_start), 0);
    chk("rst_inf_bank", 32'(inf_bank), 0);
    chk("rst_resync_cnt", 32'(resync_cnt), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    exp_wr.delete();
    exp_fr.delete();
    m_idx = '0;
    m_wb = 0;
    m_resync = 0;
    n_starts = 0;
    rst = 0;
  endtask
  initial begin
    do_reset();
    for (int i = 0; i < 784; i++) send(i < 392, i == 0, 1'b0);
    wait_starts(1);
    chk("frame_cnt_1", 32'(frame_cnt), 1);
    for (int i = 0; i < 784; i++) send(1'($urandom_range(1, 0)), i == 0, 1'b0);
    chk("bp_ready", 32'(in_ready), 0);
    in_valid = 1;
    in_pixel = 1;
    in_sof = 1;
    repeat (5) @(negedge clk);
    chk("bp_hold", 32'(in_ready), 0);
    chk("bp_no_start", n_starts, 1);
    in_valid = 0;
    pulse_done();
    chk("ready_after_done", 32'(in_ready), 1);
    wait_starts(2);
    for (int i = 0; i < 500; i++) send(1'(i % 3 == 0), i == 0, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 784; i++) send(1'(i % 5 == 0), 1'b0, 1'b0);
    chk("resync_cnt", 32'(resync_cnt), m_resync);
    chk("ready_wbank_busy", 32'(in_ready), 0);
    pulse_done();
    wait_starts(3);
    idle(3);
    chk("resync_one_start", n_starts, 3);
    for (int i = 0; i < 783; i++) send(1'(i % 7 < 3), i == 0, 1'b0);
    send(1'b1, 1'b0, 1'b1);
    chk("ready_after_sim_done", 32'(in_ready), 1);
    wait_starts(4);
    idle(3);
    chk("sim_no_double", n_starts, 4);
    chk("frame_cnt_4", 32'(frame_cnt), 4);
    for (int i = 0; i < 300; i++) send(1'b1, i == 0, 1'b0);
    idle(2);
    do_reset();
    pulse_done();
    idle(3);
    chk("stray_done_start", n_starts, 0);
    chk("stray_done_ready", 32'(in_ready), 1);
    for (int i = 0; i < 784; i++) send(1'(i % 2), i == 0, 1'b0);
    wait_starts(1);
    idle(2);
    do_reset();
    pulse_done();
    idle(3);
    chk("run_rst_start", n_starts, 0);
    chk("run_rst_frame_cnt", 32'(frame_cnt), 0);
    chk("run_rst_ready", 32'(in_ready), 1);
    auto_eng = 1;
    for (int f = 0; f < 10; f++)
      for (int i = 0; i < 784; i++) begin
        send(1'($urandom_range(1, 0)), i == 0, 1'b0);
        if ($urandom_range(3, 0) == 0) idle($urandom_range(3, 1));
      end
    wait_starts(10);
    @(negedge clk);
    chk("frame_cnt_10", 32'(frame_cnt), 10);
    chk("rand_resync_cnt", 32'(resync_cnt), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mnist_fb_ctrl.md
Name: mnist_fb_ctrl

Overview:
Ping-pong controller for the 28x28 binary MNIST frame buffer. It accepts a pixel stream through a valid/ready handshake and writes each frame into one of two 784-entry banks. When a bank holds a complete frame, it hands that bank to the inference engine with a start/done handshake. The block sits between the pixel source (capture path or test-pattern writer) and the dual-bank frame-buffer RAM plus classifier.

Parameters:
NPIX, 784, pixels per frame (28x28)
ADDR_W, 10, pixel address width; must satisfy 2^ADDR_W >= NPIX

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  pixel valid from source
in_ready  out  1  controller can accept a pixel this cycle
in_pixel  in  1  binary pixel value
in_sof  in  1  marks the first pixel of a frame; qualified by in_valid
fb_wr_en  out  1  frame-buffer write strobe
fb_wr_addr  out  ADDR_W+1  {bank, pixel index}
fb_wr_data  out  1  pixel to write
inf_start  out  1  one-cycle pulse: inference may begin on inf_bank
inf_bank  out  1  bank the inference engine must read; held stable while inference is running
inf_done  in  1  one-cycle pulse from engine: bank released
resync_cnt  out  8  count of frames cut short by in_sof, saturating
frame_cnt  out  16  count of completed frames handed to inference, wrapping

Behaviour:
- Reset: all of the following are cleared synchronously on the clk edge while rst=1:
  - in_ready=0, fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0
  - inf_start=0, inf_bank=0
  - resync_cnt=0, frame_cnt=0
  - both banks FREE, write bank=0, pixel index=0, reader IDLE
- Reset asserted mid-frame or mid-inference discards the partial frame and all bank state. A later inf_done is ignored while the reader is IDLE.
- Bank state, per bank: FREE -> FILLING -> FULL -> BUSY -> FREE.
- Accept rule:
  - A pixel is accepted when in_valid && in_ready.
  - in_ready=1 only when the current write bank is FREE or FILLING.
  - in_ready is derived from registered state only; it has no combinational path from in_valid.
- Write timing:
  - An accepted pixel produces fb_wr_en=1, fb_wr_addr={wbank, idx}, fb_wr_data=in_pixel on the next cycle (1-cycle registered latency).
  - idx then increments.
- Frame end: the pixel accepted at idx==NPIX-1 causes the following:
  - idx wraps to 0.
  - The bank becomes FULL.
  - The write bank toggles to the other bank.
  - If the other bank is not FREE, in_ready stays 0 (backpressure) until it becomes FREE.
- SOF resync:
  - in_sof accepted with idx!=0: the partial frame is abandoned, the pixel is written at addr {wbank,0}, idx becomes 1, and resync_cnt increments (saturating at 255).
  - in_sof with idx==0: normal.
  - A pixel without in_sof at idx==0 is accepted as a frame start.
- Reader FSM:
  - IDLE -> START when any bank is FULL, taking the lower-numbered bank if both are FULL.
  - START: inf_start=1 for exactly one cycle, inf_bank=chosen bank, bank goes to BUSY, frame_cnt increments.
  - START -> RUN.
  - RUN -> IDLE on inf_done, and the BUSY bank becomes FREE.
- inf_start is never asserted in the same cycle as the final fb_wr_en of that bank's frame; it fires at earliest 1 cycle after that write.
- Simultaneous events:
  - inf_done in the same cycle a frame completes: the freed bank is FREE next cycle.
  - in_ready may rise the cycle after inf_done.
  - The newly FULL bank is started by the reader the cycle after it returns to IDLE.
- inf_done while the reader is not in RUN is ignored.

Decomposition:
- Shared package mnist_pkg:
  - NPIX=784, IMG_W=28, ADDR_W=10
  - bank-state encoding FREE/FILLING/FULL/BUSY
  - reader state encoding IDLE/START/RUN
- One sub-module is natural: mnist_fb_bank_tracker, which holds the two bank-state registers and the FULL-priority select.
- Pixel counter, write port and reader FSM stay in the top module.

Test Plan:
- Reset, then 784 accepted pixels (sof on the first; pixel=1 for idx<392, else 0) -> fb_wr_addr {0,0..783}, correct data, 1-cycle lag; inf_start pulse with inf_bank=0 one or more cycles after addr {0,783}; frame_cnt=1.
- Engine holds bank 0 (no inf_done) while frame 2 fills bank 1 and frame 3 is offered -> in_ready=0 after bank-1 pixel 783. Pulse inf_done -> in_ready=1 the next cycle; inf_start with inf_bank=1.
- Assert in_sof at idx=500 -> write at addr {wbank,0}, resync_cnt=1, a further 783 pixels complete the frame, exactly one inf_start.
- inf_done in the same cycle as a frame's pixel 783 is accepted -> no lost frame, no double start, bank states consistent.
- Assert rst at idx=300 and again during RUN -> all outputs 0 next cycle; a stray inf_done after reset produces no effect; the next frame writes bank 0 from addr 0.
- Random in_valid gaps over 10 frames with the engine responding after 5–2000 cycles -> the scoreboard checks every frame's contents in the bank reported by inf_bank; frame_cnt=10.
